dac_spi_receiver: RTL and testbench
===================================

DAC_SPI_RECEIVER -- requirements
Module: dac_spi_receiver

Interface
REQ-001 Parameter: N_CHIPS, default 3, number of DAC chips, each with its own chip select.
REQ-002 Parameter: CH_PER_CHIP, default 8, channels per chip.
REQ-003 Parameter: DATA_W, default 12, threshold code width; N_CHIPS*CH_PER_CHIP*DATA_W SHALL equal 288.
REQ-004 Port: clk  input  1  system clock; the block is oversampled, with clk at least 4x sclk.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: dac_spi  input  7  DAC serial bus: [0] sclk, [1] sdi, [2] sdo (ignored), [3] ldac_n, [6:4] sync_n[2:0] (one per chip).
REQ-007 Port: dac_threshs_rb  output  288  reconstructed DAC output codes; channel k occupies [k*12 +: 12], where k = chip*8 + addr.
REQ-008 Port: frame_valid  output  1  one-cycle pulse when a well-formed frame is accepted.
REQ-009 Port: frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-010 Port: err_code  output  2  reason for the last error: 0 none, 1 bad bit count, 2 multiple selects, 3 bad address; held until the next frame_valid or frame_err.

Function
REQ-011 The block SHALL pass all seven dac_spi bits through a 2-flop synchronizer; every edge detect uses the synchronized copies.
REQ-012 Frame start SHALL be the falling edge of exactly one sync_n bit while the FSM is in IDLE; that chip index is latched.
REQ-013 Each synchronized sclk rising edge inside a frame SHALL shift sdi into a 24-bit shift register, MSB first, and increment a 5-bit bit counter that saturates at 31.
REQ-014 Frame end SHALL be the rising edge of the latched sync_n bit.
REQ-015 Frame layout: cmd[23:20], addr[19:16], data[15:4], don't-care[3:0].
REQ-016 FSM states: IDLE -> SHIFT on frame start; SHIFT -> CHECK on frame end; CHECK -> IDLE after one cycle.
REQ-017 In CHECK, a bit count other than 24 SHALL cause frame_err with err_code 1 and no register update.
REQ-018 In CHECK, addr >= CH_PER_CHIP SHALL cause frame_err with err_code 3 and no register update.
REQ-019 Command 0x0 SHALL write data to input_reg[chip][addr] only.
REQ-020 Command 0x3 SHALL write data to both input_reg and output_reg for that channel.
REQ-021 Command 0x1 SHALL copy every input_reg of the latched chip to its output_reg.
REQ-022 Any other command code SHALL be accepted (frame_valid pulses) with no register change.
REQ-023 In CHECK, frame_valid SHALL pulse for every frame that passes the REQ-017/018 checks, the cycle after CHECK; latency from frame end is 2 cycles after synchronization.
REQ-024 A synchronized falling edge of ldac_n, in any state, SHALL copy every input_reg of every chip to output_reg on the next cycle.
REQ-025 If an ldac_n edge and a CHECK update occur in the same cycle, the command update SHALL be applied first and the LDAC copy SHALL see the new input_reg value.
REQ-026 If, in SHIFT, any sync_n other than the latched one goes low, the frame SHALL be aborted: frame_err with err_code 2, return to IDLE, and no update.
REQ-027 If, in IDLE, two or more sync_n fall in the same cycle, the block SHALL pulse frame_err with err_code 2 and stay in IDLE.
REQ-028 dac_threshs_rb SHALL be the concatenation of all output_regs and SHALL be registered with no combinational path from dac_spi.

Reset
REQ-029 Reset SHALL set: FSM to IDLE; all input_reg and output_reg to 0; dac_threshs_rb to 0; frame_valid and frame_err to 0; err_code to 0; bit counter to 0.
REQ-030 The synchronizer flops SHALL reset to sync_n=all-1, ldac_n=1, sclk=0, sdi=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL ignore the bus until the next valid falling edge of sync_n.

Structure
REQ-032 Shared package dac_pkg SHALL hold: DATA_W, CH_PER_CHIP, N_CHIPS, FRAME_BITS=24, the command codes (CMD_WR_IN=0, CMD_UPD=1, CMD_WR_UPD=3), the err_code enum, the FSM state enum, and the dac_spi bit-index constants.
REQ-033 The sub-module dac_spi_sync SHALL hold the 2-flop synchronizer plus rise/fall detection for the 7 bits.
REQ-034 All state and registers SHALL live in dac_spi_receiver.

Verification
REQ-035 Scenario: reset, then sync_n[1] frame cmd=3, addr=5, data=0xABC -> frame_valid once; dac_threshs_rb[13*12 +: 12] = 0xABC; all other bits 0.
REQ-036 Scenario: sync_n[0] frame cmd=0, addr=2, data=0x123 -> output unchanged; then ldac_n low pulse -> dac_threshs_rb[2*12 +: 12] = 0x123.
REQ-037 Scenario: a 23-clock frame, then a 25-clock frame -> two frame_err pulses, err_code=1, output unchanged.
REQ-038 Scenario: frame with addr=9 -> frame_err, err_code=3; then sync_n[2] drops during a sync_n[0] frame -> frame_err, err_code=2, FSM in IDLE.
REQ-039 Scenario: rst pulsed after bit 12 of a cmd=3 frame, then a clean cmd=3, addr=0, data=0xFFF frame -> only channel 0 = 0xFFF, no spurious frame_valid.
REQ-040 Scenario: cmd=0 frame ending in the same cycle as an ldac_n fall -> the new data appears on the output (REQ-025).

Source files
------------

// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Brief    : Shared constants and types for the DAC serial-bus receiver.
// Revision : 1.0 - initial release
// ============================================================================
package dac_pkg;

    localparam int DATA_W      = 12;
    localparam int CH_PER_CHIP = 8;
    localparam int N_CHIPS     = 3;
    localparam int FRAME_BITS  = 24;

    // Bit positions inside the dac_spi bus
    localparam int c_SPI_SCLK     = 0;
    localparam int c_SPI_SDI      = 1;
    localparam int c_SPI_SDO      = 2;
    localparam int c_SPI_LDAC_N   = 3;
    localparam int c_SPI_SYNC_LSB = 4;

    localparam logic [3:0] CMD_WR_IN  = 4'h0;
    localparam logic [3:0] CMD_UPD    = 4'h1;
    localparam logic [3:0] CMD_WR_UPD = 4'h3;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BITS      = 2'd1,
        ERR_MULTI_SEL = 2'd2,
        ERR_ADDR      = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dac_spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_sync
// Brief    : Two-flop synchronizer with rise/fall detection for the DAC bus.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_sync #(
    parameter int           W       = 7,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    logic [W-1:0] r_meta_q;
    logic [W-1:0] r_sync_q;
    logic [W-1:0] r_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta_q <= RST_VAL;
            r_sync_q <= RST_VAL;
            r_prev_q <= RST_VAL;
        end else begin
            r_meta_q <= i_async;
            r_sync_q <= r_meta_q;
            r_prev_q <= r_sync_q;
        end
    end

    assign o_sync = r_sync_q;
    assign o_rise = r_sync_q & ~r_prev_q;
    assign o_fall = ~r_sync_q & r_prev_q;

endmodule
`default_nettype wire

// File: rtl/dac_spi_receiver.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_receiver
// Brief    : Snoops a multi-chip DAC serial bus and rebuilds the DAC output codes.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_receiver #(
    parameter int N_CHIPS     = dac_pkg::N_CHIPS,
    parameter int CH_PER_CHIP = dac_pkg::CH_PER_CHIP,
    parameter int DATA_W      = dac_pkg::DATA_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_CHIPS+3:0]                    dac_spi,
    output logic [N_CHIPS*CH_PER_CHIP*DATA_W-1:0] dac_threshs_rb,
    output logic                                  frame_valid,
    output logic                                  frame_err,
    output logic [1:0]                            err_code
);
    import dac_pkg::*;

    localparam int c_N_CH   = N_CHIPS * CH_PER_CHIP;
    localparam int c_BUS_W  = N_CHIPS + 4;
    localparam int c_IDX_W  = $clog2(c_N_CH);
    localparam int c_CHIP_W = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
    localparam logic [c_BUS_W-1:0] c_BUS_IDLE = {{N_CHIPS{1'b1}}, 4'b1000};

    logic [c_BUS_W-1:0] w_bus, w_rise, w_fall;

    dac_spi_sync #(
        .W       (c_BUS_W),
        .RST_VAL (c_BUS_IDLE)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (dac_spi),
        .o_sync  (w_bus),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    state_e                r_state_q, w_state_d;
    err_code_e             r_err_code_q, w_err_code_d;
    logic [c_CHIP_W-1:0]   r_chip_q, w_chip_d, w_start_chip;
    logic [FRAME_BITS-1:0] r_shift_q, w_shift_d;
    logic [4:0]            r_cnt_q, w_cnt_d;
    logic                  r_valid_q, w_valid_d;
    logic                  r_err_q, w_err_d;
    logic                  r_ldac_pend_q, w_ldac_pend_d;
    logic                  r_armed_q, w_armed_d;
    logic [1:0]            r_settle_q;
    logic [DATA_W-1:0]     r_in_q [c_N_CH];
    logic [DATA_W-1:0]     w_in_d [c_N_CH];
    logic [DATA_W-1:0]     r_out_q [c_N_CH];
    logic [DATA_W-1:0]     w_out_d [c_N_CH];

    logic [N_CHIPS-1:0] w_sync_fall, w_sync_rise, w_sel_mask;
    logic [3:0]         w_cmd, w_addr;
    logic [DATA_W-1:0]  w_data;
    logic [c_IDX_W-1:0] w_base, w_idx;
    logic               w_unused_bits;

    assign w_sync_fall = w_fall[c_SPI_SYNC_LSB +: N_CHIPS];
    assign w_sync_rise = w_rise[c_SPI_SYNC_LSB +: N_CHIPS];
    assign w_cmd       = r_shift_q[23:20];
    assign w_addr      = r_shift_q[19:16];
    assign w_data      = r_shift_q[15:4];
    assign w_base      = c_IDX_W'(r_chip_q) * c_IDX_W'(CH_PER_CHIP);
    assign w_idx       = w_base + c_IDX_W'(w_addr);
    assign w_unused_bits = ^{w_bus, w_rise, w_fall, r_shift_q[3:0]};

    always_comb begin
        w_sel_mask   = '0;
        w_start_chip = '0;
        for (int c = 0; c < N_CHIPS; c++) begin
            w_sel_mask[c] = (r_chip_q == c_CHIP_W'(c));
            if (w_sync_fall[c]) w_start_chip = c_CHIP_W'(c);
        end
    end

    // The bus is only trusted once the synchronizer holds real samples and every
    // select has been seen high, so a select held low across reset cannot open a frame.
    assign w_armed_d     = r_armed_q | (r_settle_q[1] & (&w_bus[c_SPI_SYNC_LSB +: N_CHIPS]));
    assign w_ldac_pend_d = w_fall[c_SPI_LDAC_N];

    always_comb begin
        w_state_d    = r_state_q;
        w_chip_d     = r_chip_q;
        w_shift_d    = r_shift_q;
        w_cnt_d      = r_cnt_q;
        w_valid_d    = 1'b0;
        w_err_d      = 1'b0;
        w_err_code_d = r_err_code_q;
        w_in_d       = r_in_q;
        w_out_d      = r_out_q;
        case (r_state_q)
            ST_IDLE: begin
                if (r_armed_q && (|w_sync_fall)) begin
                    if ($onehot(w_sync_fall)) begin
                        w_state_d = ST_SHIFT;
                        w_chip_d  = w_start_chip;
                        w_shift_d = '0;
                        w_cnt_d   = '0;
                    end else begin
                        w_err_d      = 1'b1;
                        w_err_code_d = ERR_MULTI_SEL;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_rise[c_SPI_SCLK]) begin
                    w_shift_d = {r_shift_q[FRAME_BITS-2:0], w_bus[c_SPI_SDI]};
                    if (r_cnt_q != 5'd31) w_cnt_d = r_cnt_q + 5'd1;
                end
                if (|(w_sync_fall & ~w_sel_mask)) begin
                    w_state_d    = ST_IDLE;
                    w_err_d      = 1'b1;
                    w_err_code_d = ERR_MULTI_SEL;
                end else if (|(w_sync_rise & w_sel_mask)) begin
                    w_state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_d = ST_IDLE;
                if (r_cnt_q != 5'(FRAME_BITS)) begin
                    w_err_d      = 1'b1;
                    w_err_code_d = ERR_BITS;
                end else if (32'(w_addr) >= CH_PER_CHIP) begin
                    w_err_d      = 1'b1;
                    w_err_code_d = ERR_ADDR;
                end else begin
                    w_valid_d    = 1'b1;
                    w_err_code_d = ERR_NONE;
                    case (w_cmd)
                        CMD_WR_IN: w_in_d[w_idx] = w_data;
                        CMD_WR_UPD: begin
                            w_in_d[w_idx]  = w_data;
                            w_out_d[w_idx] = w_data;
                        end
                        CMD_UPD: begin
                            for (int a = 0; a < CH_PER_CHIP; a++)
                                w_out_d[w_base + c_IDX_W'(a)] = r_in_q[w_base + c_IDX_W'(a)];
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        // LDAC is applied one cycle late so a command finishing alongside it lands first
        if (r_ldac_pend_q) begin
            for (int k = 0; k < c_N_CH; k++) w_out_d[k] = w_in_d[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_err_code_q  <= ERR_NONE;
            r_chip_q      <= '0;
            r_shift_q     <= '0;
            r_cnt_q       <= '0;
            r_valid_q     <= 1'b0;
            r_err_q       <= 1'b0;
            r_ldac_pend_q <= 1'b0;
            r_armed_q     <= 1'b0;
            r_settle_q    <= '0;
            r_in_q        <= '{default: '0};
            r_out_q       <= '{default: '0};
        end else begin
            r_state_q     <= w_state_d;
            r_err_code_q  <= w_err_code_d;
            r_chip_q      <= w_chip_d;
            r_shift_q     <= w_shift_d;
            r_cnt_q       <= w_cnt_d;
            r_valid_q     <= w_valid_d;
            r_err_q       <= w_err_d;
            r_ldac_pend_q <= w_ldac_pend_d;
            r_armed_q     <= w_armed_d;
            r_settle_q    <= {r_settle_q[0], 1'b1};
            r_in_q        <= w_in_d;
            r_out_q       <= w_out_d;
        end
    end

    generate
        for (genvar k = 0; k < c_N_CH; k++) begin : g_flat
            assign dac_threshs_rb[k*DATA_W +: DATA_W] = r_out_q[k];
        end
    endgenerate

    assign frame_valid = r_valid_q;
    assign frame_err   = r_err_q;
    assign err_code    = r_err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_receiver
// Brief    : Directed self-checking bench for dac_spi_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_spi_receiver;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   dac_spi;
    logic [287:0] dac_threshs_rb;
    logic         frame_valid;
    logic         frame_err;
    logic [1:0]   err_code;

    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;
    int n_err   = 0;
    logic [287:0] exp_rb;

    always #5 clk = ~clk;

    dac_spi_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .dac_spi        (dac_spi),
        .dac_threshs_rb (dac_threshs_rb),
        .frame_valid    (frame_valid),
        .frame_err      (frame_err),
        .err_code       (err_code)
    );

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err)   n_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            dac_spi[0] = 1'b0;
            dac_spi[1] = (i < 24) ? w[23-i] : 1'b0;
            tick(4);
            dac_spi[0] = 1'b1;
            tick(4);
        end
        dac_spi[0] = 1'b0;
    endtask

    task automatic send_frame(input int chip, input logic [23:0] w, input int n, input bit ldac_at_end);
        dac_spi[4+chip] = 1'b0;
        tick(4);
        send_bits(w, n);
        tick(4);
        dac_spi[4+chip] = 1'b1;
        if (ldac_at_end) dac_spi[3] = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        dac_spi = 7'b111_1000;
        tick(3);
        check("reset_rb", dac_threshs_rb, '0);
        check("reset_flags", {frame_valid, frame_err, err_code}, '0);
        rst = 1'b0;
        tick(5);

        // chip 1, write-and-update channel 5 -> flat channel 13
        send_frame(1, 24'h35ABC0, 24, 1'b0);
        tick(3);
        check("valid_latency_early", frame_valid, 1'b0);
        tick(1);
        check("valid_latency", frame_valid, 1'b1);
        tick(1);
        check("valid_one_cycle", frame_valid, 1'b0);
        tick(6);
        exp_rb = '0;
        exp_rb[13*12 +: 12] = 12'hABC;
        check("wr_upd_rb", dac_threshs_rb, exp_rb);
        check("wr_upd_valid_cnt", n_valid, 1);
        check("wr_upd_err_cnt", n_err, 0);

        // chip 0, write input only, then LDAC
        send_frame(0, 24'h021230, 24, 1'b0);
        tick(10);
        check("wr_in_hold_rb", dac_threshs_rb, exp_rb);
        check("wr_in_valid_cnt", n_valid, 2);
        dac_spi[3] = 1'b0;
        tick(6);
        dac_spi[3] = 1'b1;
        tick(6);
        exp_rb[2*12 +: 12] = 12'h123;
        check("ldac_rb", dac_threshs_rb, exp_rb);

        // short and long frames
        send_frame(0, 24'h315550, 23, 1'b0);
        tick(10);
        send_frame(0, 24'h315550, 25, 1'b0);
        tick(10);
        check("bitcnt_err_cnt", n_err, 2);
        check("bitcnt_err_code", err_code, 2'd1);
        check("bitcnt_rb", dac_threshs_rb, exp_rb);
        check("bitcnt_valid_cnt", n_valid, 2);

        // out-of-range address
        send_frame(2, 24'h397770, 24, 1'b0);
        tick(10);
        check("addr_err_cnt", n_err, 3);
        check("addr_err_code", err_code, 2'd3);
        check("addr_rb", dac_threshs_rb, exp_rb);

        // second select drops mid-frame
        dac_spi[4] = 1'b0;
        tick(4);
        send_bits(24'h312220, 8);
        dac_spi[6] = 1'b0;
        tick(10);
        check("abort_err_cnt", n_err, 4);
        check("abort_err_code", err_code, 2'd2);
        dac_spi[4] = 1'b1;
        dac_spi[6] = 1'b1;
        tick(10);
        check("abort_quiet_err_cnt", n_err, 4);
        send_frame(2, 24'h375A50, 24, 1'b0);
        tick(10);
        exp_rb[23*12 +: 12] = 12'h5A5;
        check("after_abort_rb", dac_threshs_rb, exp_rb);
        check("after_abort_valid_cnt", n_valid, 3);
        check("after_abort_err_code", err_code, 2'd0);

        // two selects fall together in IDLE
        dac_spi[4] = 1'b0;
        dac_spi[5] = 1'b0;
        tick(10);
        check("multi_err_cnt", n_err, 5);
        check("multi_err_code", err_code, 2'd2);
        dac_spi[5:4] = 2'b11;
        tick(10);
        check("multi_valid_cnt", n_valid, 3);

        // reset in the middle of a frame, select still low at release
        dac_spi[5] = 1'b0;
        tick(4);
        send_bits(24'h347770, 12);
        rst = 1'b1;
        tick(3);
        check("midrst_rb", dac_threshs_rb, '0);
        check("midrst_flags", {frame_valid, frame_err, err_code}, '0);
        rst = 1'b0;
        tick(10);
        dac_spi[5] = 1'b1;
        tick(10);
        check("midrst_valid_cnt", n_valid, 3);
        check("midrst_err_cnt", n_err, 5);
        send_frame(0, 24'h30FFF0, 24, 1'b0);
        tick(10);
        exp_rb = '0;
        exp_rb[11:0] = 12'hFFF;
        check("post_rst_rb", dac_threshs_rb, exp_rb);
        check("post_rst_valid_cnt", n_valid, 4);

        // write-input frame ending together with an LDAC fall
        send_frame(2, 24'h019C30, 24, 1'b1);
        tick(10);
        dac_spi[3] = 1'b1;
        tick(6);
        exp_rb[17*12 +: 12] = 12'h9C3;
        check("ldac_same_cycle_rb", dac_threshs_rb, exp_rb);
        check("ldac_same_cycle_valid_cnt", n_valid, 5);
        check("final_err_cnt", n_err, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
